// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser and glitch filter feeding
// registered rise/fall pulses, mode-gated events, sticky pending flags and saturating counts.
module edge_detect_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH-1:0]         a_i,
    input  logic [2*CH-1:0]       mode_i,
    input  logic [CH-1:0]         clear_i,
    output logic [CH-1:0]         rising_edge_o,
    output logic [CH-1:0]         falling_edge_o,
    output logic [CH-1:0]         event_o,
    output logic [CH-1:0]         pending_o,
    output logic [CH*CNT_W-1:0]   count_o,
    output logic                  irq_o
);

    localparam int              FW        = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FW-1:0]   FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] r_sync [CH];
    logic [FW-1:0]          r_fcnt [CH];
    logic [CNT_W-1:0]       r_cnt  [CH];
    logic [CH-1:0]          r_filt;
    logic [CH-1:0]          r_prev;
    logic [CH-1:0]          r_rise;
    logic [CH-1:0]          r_fall;
    logic [CH-1:0]          r_evt;
    logic [CH-1:0]          r_pend;
    logic                   r_irq;

    logic [CH-1:0]          w_sync;
    logic [CH-1:0]          w_mode_r;
    logic [CH-1:0]          w_mode_f;
    logic [CH-1:0]          w_rise;
    logic [CH-1:0]          w_fall;
    logic [CH-1:0]          w_evt;

    always_comb begin
        w_sync   = '0;
        w_mode_r = '0;
        w_mode_f = '0;
        for (int c = 0; c < CH; c++) begin
            w_sync[c]   = r_sync[c][SYNC_STAGES-1];
            w_mode_r[c] = mode_i[2*c];
            w_mode_f[c] = mode_i[2*c+1];
        end
    end

    // r_prev lags the filtered level by one cycle, so these are true for exactly one cycle per change
    assign w_rise = r_filt & ~r_prev;
    assign w_fall = ~r_filt & r_prev;
    assign w_evt  = (w_rise & w_mode_r) | (w_fall & w_mode_f);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CH; c++) begin
                r_sync[c] <= '0;
                r_fcnt[c] <= '0;
                r_cnt[c]  <= '0;
            end
            r_filt <= '0;
            r_prev <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_evt  <= '0;
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= r_filt;
            r_rise <= w_rise;
            r_fall <= w_fall;
            r_evt  <= w_evt;
            r_pend <= w_evt | (r_pend & ~clear_i);
            r_irq  <= |r_pend;
            for (int c = 0; c < CH; c++) begin
                r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], a_i[c]};

                if (w_sync[c] == r_filt[c]) begin
                    r_fcnt[c] <= '0;
                end else if (r_fcnt[c] == FILT_LAST) begin
                    r_filt[c] <= w_sync[c];
                    r_fcnt[c] <= '0;
                end else begin
                    r_fcnt[c] <= r_fcnt[c] + FW'(1);
                end

                // A clear coinciding with an event keeps that event: the count restarts at 1
                if (clear_i[c]) begin
                    r_cnt[c] <= w_evt[c] ? CNT_W'(1) : '0;
                end else if (w_evt[c] && (r_cnt[c] != CNT_MAX)) begin
                    r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_cnt
        assign count_o[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    assign rising_edge_o  = r_rise;
    assign falling_edge_o = r_fall;
    assign event_o        = r_evt;
    assign pending_o      = r_pend;
    assign irq_o          = r_irq;

endmodule
